// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package : fft_pkg
// Purpose : Types and constants shared by the 4-point FFT datapath: the
//           sample framer, the fft_n4 wrappers and the output serializer.
// Contents: FFT_N           - points per transform
//           DEFAULT_DATA_W  - default sample width in bits
//           sample_t        - one real sample at the default width
//           frame_idx_t     - position of a sample within a 4-sample frame
// Revision: 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N          = 4;
  localparam int DEFAULT_DATA_W = 32;

  typedef logic [DEFAULT_DATA_W-1:0] sample_t;
  typedef logic [1:0]                frame_idx_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft4_sample_framer.sv
`default_nettype none
// ============================================================================
// Module  : fft4_sample_framer
// Purpose : Groups a serial stream of real samples into 4-sample frames
//           (x0..x3, natural order) and presents each frame in parallel on
//           m_a..m_d for the fft_n4 stage. A three-entry fill bank collects
//           x0..x2 while the previous frame is held in the output bank; x3
//           bypasses the fill bank and loads the output bank directly.
// Ports   : clk, rst_n           - clock, asynchronous active-low reset
//           s_valid/s_ready      - input sample handshake
//           s_data, s_sof        - input sample and start-of-frame marker
//           m_valid/m_ready      - output frame handshake
//           m_a, m_b, m_c, m_d   - frame samples x0, x1, x2, x3
//           fill_idx             - samples held in the partial frame (0..3)
//           drop_cnt             - saturating count of discarded partials
// Revision: 1.0 - initial release
// ============================================================================
module fft4_sample_framer
  import fft_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_a,
  output logic [DATA_W-1:0] m_b,
  output logic [DATA_W-1:0] m_c,
  output logic [DATA_W-1:0] m_d,
  output frame_idx_t        fill_idx,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam frame_idx_t LAST_IDX = 2'd3;

  logic [DATA_W-1:0] f0;
  logic [DATA_W-1:0] f1;
  logic [DATA_W-1:0] f2;

  logic in_fire;
  logic out_fire;
  logic frame_load;

  // Only the 4th (non-sof) sample needs the output bank, so the input
  // stalls only when the fill bank is full and the held frame is not
  // leaving this cycle. A sof sample at fill_idx=3 also waits here, which
  // is harmless: it is simply accepted one cycle later.
  assign s_ready    = (fill_idx != LAST_IDX) | ~m_valid | m_ready;
  assign in_fire    = s_valid & s_ready;
  assign out_fire   = m_valid & m_ready;
  assign frame_load = in_fire & ~s_sof & (fill_idx == LAST_IDX);

  // Fill bank and frame position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0       <= '0;
      f1       <= '0;
      f2       <= '0;
      fill_idx <= '0;
    end else if (in_fire) begin
      if (s_sof) begin
        // A sof sample always restarts the frame as x0.
        f0       <= s_data;
        fill_idx <= 2'd1;
      end else begin
        case (fill_idx)
          2'd0:    f0 <= s_data;
          2'd1:    f1 <= s_data;
          2'd2:    f2 <= s_data;
          default: ;  // x3 goes straight to the output bank
        endcase
        fill_idx <= (fill_idx == LAST_IDX) ? 2'd0 : fill_idx + 2'd1;
      end
    end
  end

  // Dropped partial-frame counter (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_fire && s_sof && (fill_idx != 2'd0) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // Output bank. A load can coincide with an output transfer, in which case
  // m_valid stays high and the new frame replaces the consumed one. A load
  // never happens while a held frame is stalled, because s_ready is low then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_c     <= '0;
      m_d     <= '0;
    end else if (frame_load) begin
      m_valid <= 1'b1;
      m_a     <= f0;
      m_b     <= f1;
      m_c     <= f2;
      m_d     <= s_data;
    end else if (out_fire) begin
      m_valid <= 1'b0;
    end
  end

endmodule : fft4_sample_framer
`default_nettype wire

// File: tb/tb_fft4_sample_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft4_sample_framer
// Purpose : Self-checking bench for fft4_sample_framer. A queue-based frame
//           model predicts every output; directed sequences cover the basic
//           stream, back-pressure, sof drops, counter saturation and
//           mid-frame reset, followed by a randomized handshake run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft4_sample_framer;

  localparam int DW  = 32;
  localparam int DRW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  s_data = '0;
  logic           s_sof = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_a, m_b, m_c, m_d;
  logic [1:0]     fill_idx;
  logic [DRW-1:0] drop_cnt;

  fft4_sample_framer #(.DATA_W(DW), .DROP_W(DRW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_a      (m_a),
    .m_b      (m_b),
    .m_c      (m_c),
    .m_d      (m_d),
    .fill_idx (fill_idx),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: samples of the partial frame, the held frame, drops.
  logic [DW-1:0] part[$];
  bit            held;
  logic [DW-1:0] frm[4];
  int            drops;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    part.delete();
    held  = 1'b0;
    drops = 0;
    for (int i = 0; i < 4; i++) frm[i] = '0;
  endfunction

  // One clock cycle: drive inputs on the falling edge, compare every output
  // with the model, then advance the model to what the next rising edge does.
  task automatic step(input bit sv, input logic [DW-1:0] sd, input bit sof,
                      input bit mr, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    s_sof   = sof;
    m_ready = mr;
    #1;
    exp_rdy = (part.size() != 3) || !held || mr;
    check("s_ready",  s_ready,  exp_rdy);
    check("m_valid",  m_valid,  held);
    check("fill_idx", fill_idx, part.size());
    check("drop_cnt", drop_cnt, drops);
    if (held) begin
      check("m_a", m_a, frm[0]);
      check("m_b", m_b, frm[1]);
      check("m_c", m_c, frm[2]);
      check("m_d", m_d, frm[3]);
    end
    acc = sv && exp_rdy;
    if (held && mr) held = 1'b0;
    if (acc) begin
      if (sof) begin
        if (part.size() != 0 && drops < 255) drops++;
        part.delete();
        part.push_back(sd);
      end else if (part.size() < 3) begin
        part.push_back(sd);
      end else begin
        frm[0] = part[0];
        frm[1] = part[1];
        frm[2] = part[2];
        frm[3] = sd;
        held   = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    model_reset();
    check("rst_m_valid",  m_valid,  0);
    check("rst_fill_idx", fill_idx, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_m_a", m_a, 0);
    check("rst_m_d", m_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit acc;
  int cnt;
  int cycles;
  logic [DW-1:0] next_a;

  initial begin
    model_reset();
    do_reset();

    // 1: stream 1..4 with the consumer always ready
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), (i == 1), 1'b1, acc);
      check("t1_accept", acc, 1);
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("t1_valid", m_valid, 1);
    check("t1_xr0", 64'(m_a) + 64'(m_b) + 64'(m_c) + 64'(m_d), 10);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // 2: stream 1..8 with the consumer stalled
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, DW'(i), (i == 1) || (i == 5), 1'b0, acc);
      check("t2_accept", acc, 1);
    end
    step(1'b1, DW'(8), 1'b0, 1'b0, acc);
    check("t2_stall_ready", s_ready, 0);
    check("t2_held_a", m_a, 1);
    step(1'b1, DW'(8), 1'b0, 1'b1, acc);
    check("t2_accept8", acc, 1);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("t2_new_a", m_a, 5);
    check("t2_new_d", m_d, 8);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // 3: partial {10,11} interrupted by sof on 20
    step(1'b1, DW'(10), 1'b1, 1'b1, acc);
    step(1'b1, DW'(11), 1'b0, 1'b1, acc);
    step(1'b1, DW'(20), 1'b1, 1'b1, acc);
    step(1'b1, DW'(21), 1'b0, 1'b1, acc);
    step(1'b1, DW'(22), 1'b0, 1'b1, acc);
    step(1'b1, DW'(23), 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("t3_drop", drop_cnt, 1);
    check("t3_a", m_a, 20);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // 4: saturate the drop counter with sof-interrupted partial frames
    for (int i = 0; i < 301; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b1, acc);
      step(1'b1, DW'($urandom), 1'b0, 1'b1, acc);
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    check("t4_sat", drop_cnt, 255);

    // 5: reset with a held frame and a partial frame of two samples
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), (i == 1) || (i == 5), 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_pre_fill", fill_idx, 2);
    check("t5_pre_valid", m_valid, 1);
    do_reset();
    for (int i = 5; i <= 8; i++) step(1'b1, DW'(i), (i == 5), 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_a", m_a, 5);
    check("t5_d", m_d, 8);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // 6: randomized handshakes over 1000 incrementing samples
    do_reset();
    cnt    = 1;
    cycles = 0;
    next_a = 1;
    while (cnt <= 1000 && cycles < 20000) begin
      step(1'($urandom_range(0, 1)), DW'(cnt), 1'b0, 1'($urandom_range(0, 1)), acc);
      if (m_valid && m_ready) begin
        check("t6_order", m_a, next_a);
        next_a = next_a + 4;
      end
      if (acc) cnt++;
      cycles++;
    end
    check("t6_done", cnt > 1000, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, acc);
      if (m_valid && m_ready) begin
        check("t6_order", m_a, next_a);
        next_a = next_a + 4;
      end
    end
    check("t6_all_frames", next_a, 1001);
    check("t6_drop", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fft4_sample_framer
`default_nettype wire
